// File: rtl/rvfi_commit_monitor.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_commit_monitor
// Purpose  : Multi-channel commit tracker for the RVFI monitor. Assigns a
//            monotonically increasing order to every retired instruction,
//            detects self-loop halts and flags traps, non-contiguous retire
//            slots and (optionally) commit starvation.
// Options  : RVFI_MON_WATCHDOG_EN - enables the idle-cycle watchdog that
//            drives 'timeout'; when undefined, 'timeout' is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module rvfi_commit_monitor #(
    parameter int NRET        = 2,
    parameter int XLEN        = 32,
    parameter int ORDER_W     = 64,
    parameter int HALT_REPEAT = 2,
    parameter int TIMEOUT     = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NRET-1:0]             commit_valid,
    input  logic [NRET*XLEN-1:0]        commit_pc_rdata,
    input  logic [NRET*XLEN-1:0]        commit_pc_wdata,
    input  logic [NRET-1:0]             commit_trap,
    input  logic                        clear,
    output logic [NRET*ORDER_W-1:0]     order_out,
    output logic [ORDER_W-1:0]          order_next,
    output logic [$clog2(NRET+1)-1:0]   retire_cnt,
    output logic                        halt,
    output logic                        trap_seen,
    output logic                        gap_err,
    output logic                        timeout
);

    localparam int RCNT_W = $clog2(NRET + 1);
    localparam int LCNT_W = $clog2(HALT_REPEAT + 1);
    localparam logic [LCNT_W-1:0] c_HALT_MAX = LCNT_W'(HALT_REPEAT);

    logic [ORDER_W-1:0] r_order_q;
    logic [LCNT_W-1:0]  r_loop_cnt;
    logic               r_halt;
    logic               r_trap_seen;
    logic               r_gap_err;

    logic [RCNT_W-1:0]  w_prefix [NRET];
    logic [RCNT_W-1:0]  w_retire_cnt;
    logic [NRET-1:0]    w_self_loop;
    logic [LCNT_W-1:0]  w_loop_next;
    logic               w_trap;
    logic               w_gap;

    // Running count of valid channels below each slot; the final sum is the popcount
    always_comb begin
        logic [RCNT_W-1:0] v_acc;
        v_acc = '0;
        for (int i = 0; i < NRET; i++) begin
            w_prefix[i] = v_acc;
            v_acc       = v_acc + RCNT_W'(commit_valid[i]);
        end
        w_retire_cnt = v_acc;
    end

    generate
        for (genvar gi = 0; gi < NRET; gi++) begin : g_chan
            assign w_self_loop[gi] = (commit_pc_wdata[gi*XLEN +: XLEN] == commit_pc_rdata[gi*XLEN +: XLEN]);
            // Invalid slots still get the formula value; consumers ignore them
            assign order_out[gi*ORDER_W +: ORDER_W] = r_order_q + ORDER_W'(w_prefix[gi]);
        end
    endgenerate

    // Walk channels oldest-first so a later non-loop commit breaks an earlier loop run
    always_comb begin
        logic [LCNT_W-1:0] v_loop;
        v_loop = r_loop_cnt;
        for (int i = 0; i < NRET; i++) begin
            if (commit_valid[i]) begin
                if (w_self_loop[i]) begin
                    if (v_loop != c_HALT_MAX) begin
                        v_loop = v_loop + LCNT_W'(1);
                    end
                end else begin
                    v_loop = '0;
                end
            end
        end
        w_loop_next = v_loop;
    end

    // A valid mask is contiguous from bit 0 exactly when mask & (mask+1) is zero
    assign w_gap  = |(commit_valid & (commit_valid + NRET'(1)));
    assign w_trap = |(commit_valid & commit_trap);

    // Order counter, loop tracker and sticky flags; a same-cycle set beats clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_order_q   <= '0;
            r_loop_cnt  <= '0;
            r_halt      <= 1'b0;
            r_trap_seen <= 1'b0;
            r_gap_err   <= 1'b0;
        end else begin
            r_order_q   <= r_order_q + ORDER_W'(w_retire_cnt);
            r_loop_cnt  <= w_loop_next;
            if (w_loop_next == c_HALT_MAX) begin
                r_halt <= 1'b1;
            end
            r_trap_seen <= w_trap | (r_trap_seen & ~clear);
            r_gap_err   <= w_gap  | (r_gap_err   & ~clear);
        end
    end

`ifdef RVFI_MON_WATCHDOG_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] c_TIMEOUT_MAX = IDLE_W'(TIMEOUT);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic [IDLE_W-1:0] w_idle_next;
    logic              r_timeout;

    // Idle counter: cleared by any commit, saturating, frozen once halted
    always_comb begin
        w_idle_next = r_idle_cnt;
        if (!r_halt) begin
            if (|commit_valid) begin
                w_idle_next = '0;
            end else if (r_idle_cnt != c_TIMEOUT_MAX) begin
                w_idle_next = r_idle_cnt + IDLE_W'(1);
            end
        end
    end

    // Timeout fires on the edge the counter arrives at the limit, so a clear sticks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_idle_cnt <= w_idle_next;
            r_timeout  <= ((w_idle_next == c_TIMEOUT_MAX) && (r_idle_cnt != c_TIMEOUT_MAX))
                          | (r_timeout & ~clear);
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign timeout          = 1'b0;
`endif

    assign order_next = r_order_q;
    assign retire_cnt = w_retire_cnt;
    assign halt       = r_halt;
    assign trap_seen  = r_trap_seen;
    assign gap_err    = r_gap_err;

endmodule
`default_nettype wire
